// File: rtl/memory_bus_pkg.sv
// Shared types for the memory-manager write path.
// Contents: bus widths, the queued write entry and the drain FSM state type.
package memory_bus_pkg;

   localparam int MEM_ADDR_WIDTH = 17;
   localparam int MEM_DATA_WIDTH = 8;

   typedef struct packed {
      logic [MEM_ADDR_WIDTH-1:0] addr;
      logic [MEM_DATA_WIDTH-1:0] data;
   } write_entry_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      RELEASE = 2'd2
   } write_queue_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with an explicit occupancy counter.
// Ports:
//   clock, reset     - posedge clock, synchronous active-high reset
//   push, din        - write din at the tail (ignored when full)
//   pop              - drop the head entry (ignored when empty)
//   dout             - head entry, read combinationally from storage
//   level            - occupancy 0..DEPTH
//   full, empty      - decoded from level only
// Pointers wrap modulo DEPTH; the level counter alone tells full from empty.
module sync_fifo #(
   parameter int  DEPTH  = 8,
   parameter type elem_t = logic [7:0]
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  elem_t                    din,
   output elem_t                    dout,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);

   elem_t            mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == (PW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Storage needs no reset: nothing is read until the level says it is valid.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/memory_write_queue.sv
// Host write queue in front of the memory manager's write port.
// Buffers host writes in a sync_fifo and drains them one at a time through
// the memoryWriteRequest / memoryWriteComplete handshake.
// Ports:
//   clock, reset                         - posedge clock, sync active-high reset
//   hostWriteValid/Address/Data, Ready   - host push side (Ready = not full)
//   memoryWriteRequest/Address/Data      - to manager; head entry while requesting
//   memoryWriteComplete                  - from manager; 1-cycle done pulse
//   fifoLevel, fifoEmpty                 - occupancy status
//   overflow, overflowClear              - sticky push-while-full flag and its clear
//   timeoutError                         - only with MEMORY_WRITE_QUEUE_TIMEOUT_EN
// Build option MEMORY_WRITE_QUEUE_TIMEOUT_EN: abort an entry after
// TIMEOUT_CYCLES in REQUEST without a complete, and flag timeoutError.
//
// state   | meaning
// IDLE    | waiting for a queued entry
// REQUEST | head entry presented to manager, waiting for complete
// RELEASE | one-cycle request gap after a pop
module memory_write_queue
   import memory_bus_pkg::*;
#(
   parameter int DEPTH          = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        hostWriteValid,
   input  logic [MEM_ADDR_WIDTH-1:0]   hostWriteAddress,
   input  logic [MEM_DATA_WIDTH-1:0]   hostWriteData,
   output logic                        hostWriteReady,
   output logic                        memoryWriteRequest,
   output logic [MEM_ADDR_WIDTH-1:0]   memoryWriteAddress,
   output logic [MEM_DATA_WIDTH-1:0]   memoryWriteData,
   input  logic                        memoryWriteComplete,
   output logic [$clog2(DEPTH):0]      fifoLevel,
   output logic                        fifoEmpty,
   output logic                        overflow,
   input  logic                        overflowClear
`ifdef MEMORY_WRITE_QUEUE_TIMEOUT_EN
   ,
   output logic                        timeoutError
`endif
);

   write_queue_state_t state;
   write_queue_state_t state_next;
   write_entry_t       head;
   write_entry_t       host_entry;
   logic               fifo_full;
   logic               push;
   logic               pop;
   logic               timeout_hit;

   assign host_entry     = '{addr: hostWriteAddress, data: hostWriteData};
   assign hostWriteReady = !reset && !fifo_full;
   assign push           = hostWriteValid && hostWriteReady;
   assign pop            = (state == REQUEST) && (memoryWriteComplete || timeout_hit);

   sync_fifo #(
      .DEPTH  (DEPTH),
      .elem_t (write_entry_t)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (host_entry),
      .dout  (head),
      .level (fifoLevel),
      .full  (fifo_full),
      .empty (fifoEmpty)
   );

`ifdef MEMORY_WRITE_QUEUE_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] timer;

   // Reloaded outside REQUEST so each entry gets a full TIMEOUT_CYCLES window;
   // reaching zero means this is the last REQUEST cycle allowed.
   always_ff @(posedge clock) begin
      if (reset || state != REQUEST) begin
         timer <= TW'(TIMEOUT_CYCLES - 1);
      end else if (timer != '0) begin
         timer <= timer - 1'b1;
      end
   end

   // Complete in the same cycle as expiry wins, so no error is raised.
   assign timeout_hit = (state == REQUEST) && (timer == '0) && !memoryWriteComplete;

   always_ff @(posedge clock) begin
      if (reset) begin
         timeoutError <= 1'b0;
      end else if (timeout_hit) begin
         timeoutError <= 1'b1;
      end else if (overflowClear) begin
         timeoutError <= 1'b0;
      end
   end
`else
   logic unused_timeout_param;

   assign timeout_hit          = 1'b0;
   assign unused_timeout_param = (TIMEOUT_CYCLES > 0);
`endif

   // Overflow: a new set takes priority over a clear in the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (hostWriteValid && !hostWriteReady) begin
         overflow <= 1'b1;
      end else if (overflowClear) begin
         overflow <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (!fifoEmpty) state_next = REQUEST;
         REQUEST: if (pop)        state_next = RELEASE;
         RELEASE:                 state_next = IDLE;
         default:                 state_next = IDLE;
      endcase
   end

   // Address/data follow the head directly; they stay stable through the
   // complete cycle because the pop only takes effect at that edge.
   always_comb begin
      memoryWriteRequest = (state == REQUEST);
      memoryWriteAddress = reset ? '0 : head.addr;
      memoryWriteData    = reset ? '0 : head.data;
   end

endmodule

// File: tb/tb_memory_write_queue.sv
module tb_memory_write_queue;

   localparam int DEPTH = 8;
`ifdef MEMORY_WRITE_QUEUE_TIMEOUT_EN
   localparam int TO    = 4;
   localparam bit TO_EN = 1'b1;
`else
   localparam int TO    = 64;
   localparam bit TO_EN = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        hostWriteValid = 1'b0;
   logic [16:0] hostWriteAddress = '0;
   logic [7:0]  hostWriteData = '0;
   logic        hostWriteReady;
   logic        memoryWriteRequest;
   logic [16:0] memoryWriteAddress;
   logic [7:0]  memoryWriteData;
   logic        memoryWriteComplete = 1'b0;
   logic [3:0]  fifoLevel;
   logic        fifoEmpty;
   logic        overflow;
   logic        overflowClear = 1'b0;
`ifdef MEMORY_WRITE_QUEUE_TIMEOUT_EN
   logic        timeoutError;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: a queue of {addr,data}, plus the handshake phase.
   logic [24:0] q[$];
   bit          req_m, gap_m, ovf_m, terr_m;
   int          req_cycles;

   always #5 clock = ~clock;

   memory_write_queue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
      .clock               (clock),
      .reset               (reset),
      .hostWriteValid      (hostWriteValid),
      .hostWriteAddress    (hostWriteAddress),
      .hostWriteData       (hostWriteData),
      .hostWriteReady      (hostWriteReady),
      .memoryWriteRequest  (memoryWriteRequest),
      .memoryWriteAddress  (memoryWriteAddress),
      .memoryWriteData     (memoryWriteData),
      .memoryWriteComplete (memoryWriteComplete),
      .fifoLevel           (fifoLevel),
      .fifoEmpty           (fifoEmpty),
      .overflow            (overflow),
      .overflowClear       (overflowClear)
`ifdef MEMORY_WRITE_QUEUE_TIMEOUT_EN
      ,
      .timeoutError        (timeoutError)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      int  pre;
      bit  timed_out;
      pre       = q.size();
      timed_out = 1'b0;
      if (reset) begin
         q.delete();
         req_m  = 0;
         gap_m  = 0;
         ovf_m  = 0;
         terr_m = 0;
         return;
      end
      if (req_m) begin
         if (memoryWriteComplete) begin
            void'(q.pop_front());
            req_m = 0;
            gap_m = 1;
         end else if (TO_EN && req_cycles + 1 >= TO) begin
            void'(q.pop_front());
            req_m     = 0;
            gap_m     = 1;
            timed_out = 1'b1;
         end else begin
            req_cycles++;
         end
      end else if (gap_m) begin
         gap_m = 0;
      end else if (pre > 0) begin
         req_m      = 1;
         req_cycles = 0;
      end
      if (hostWriteValid && pre < DEPTH) q.push_back({hostWriteAddress, hostWriteData});
      if (hostWriteValid && pre >= DEPTH) ovf_m = 1;
      else if (overflowClear) ovf_m = 0;
      if (timed_out) terr_m = 1;
      else if (overflowClear) terr_m = 0;
   endtask

   task automatic check_outputs();
      check_val("ready", 32'(hostWriteReady), 32'(!reset && q.size() < DEPTH));
      check_val("level", 32'(fifoLevel), 32'(q.size()));
      check_val("empty", 32'(fifoEmpty), 32'(q.size() == 0));
      check_val("overflow", 32'(overflow), 32'(ovf_m));
      check_val("request", 32'(memoryWriteRequest), 32'(req_m));
      if (reset) begin
         check_val("addr_rst", 32'(memoryWriteAddress), 32'h0);
         check_val("data_rst", 32'(memoryWriteData), 32'h0);
      end else if (req_m) begin
         check_val("addr", 32'(memoryWriteAddress), 32'(q[0][24:8]));
         check_val("data", 32'(memoryWriteData), 32'(q[0][7:0]));
      end
`ifdef MEMORY_WRITE_QUEUE_TIMEOUT_EN
      check_val("timeout_err", 32'(timeoutError), 32'(terr_m));
`endif
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic drive(input bit v, input logic [16:0] a, input logic [7:0] d,
                        input bit c, input bit clr);
      hostWriteValid      = v;
      hostWriteAddress    = a;
      hostWriteData       = d;
      memoryWriteComplete = c;
      overflowClear       = clr;
      step();
   endtask

   task automatic idle(input int n, input bit c);
      for (int i = 0; i < n; i++) drive(0, '0, '0, c, 0);
   endtask

   initial begin
      reset = 1'b1;
      idle(2, 0);
      memoryWriteComplete = 1'b1;
      step();
      reset = 1'b0;

      // Single write, complete after 3 cycles of waiting.
      drive(1, 17'h01234, 8'hA5, 0, 0);
      idle(3, 0);
      idle(1, 1);
      idle(2, 0);

      // Fill to full, overflow, clear, drain.
      for (int i = 0; i < DEPTH; i++) drive(1, 17'(32'h100 + i), 8'(i), 0, 0);
      drive(1, 17'h1FFFF, 8'hEE, 0, 0);
      idle(1, 0);
      drive(0, '0, '0, 0, 1);
      idle(30, 1);

      // Ordered drain across the pointer wrap.
      for (int i = 0; i < 8; i++) drive(1, 17'(32'h10 + i), 8'(8'h40 + i), 0, 0);
      idle(25, 1);
      for (int i = 0; i < 4; i++) drive(1, 17'(32'h18 + i), 8'(8'h50 + i), 1, 0);
      idle(15, 1);

      // Stray complete with an empty FIFO.
      idle(3, 1);

      // Reset while a request is outstanding.
      for (int i = 0; i < 3; i++) drive(1, 17'(32'h200 + i), 8'(i), 0, 0);
      idle(1, 0);
      reset = 1'b1;
      idle(1, 0);
      reset = 1'b0;
      idle(3, 1);

      // Entry never completed: waits (default) or times out (feature build).
      drive(1, 17'h00300, 8'h11, 0, 0);
      drive(1, 17'h00301, 8'h22, 0, 0);
      idle(14, 0);
      drive(0, '0, '0, 0, 1);
      idle(10, 1);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 299) == 0);
         drive(bit'($urandom_range(0, 1)), 17'($urandom), 8'($urandom),
               ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
      end
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
